fpnew_issue_rob: RTL and testbench



---
 rtl/fpnew_issue_rob_if.sv | 49 ++++
 rtl/fpnew_issue_rob.sv | 103 ++++++++++
 tb/tb_fpnew_issue_rob.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpnew_issue_rob_if.sv
// Bundles the core-side request/response port and the FPU-side issue/writeback
// port of fpnew_issue_rob.
interface fpnew_issue_rob_if #(
    parameter int unsigned Width   = 64,
    parameter int unsigned TagW    = 2,
    parameter type         ReqType = logic
);
    logic            flush_i;
    ReqType          req_i;
    logic            req_valid_i;
    logic            req_ready_o;
    ReqType          fpu_req_o;
    logic [TagW-1:0] fpu_tag_o;
    logic            fpu_in_valid_o;
    logic            fpu_in_ready_i;
    logic            fpu_flush_o;
    logic [Width-1:0] fpu_result_i;
    logic [4:0]      fpu_status_i;
    logic [TagW-1:0] fpu_tag_i;
    logic            fpu_out_valid_i;
    logic            fpu_out_ready_o;
    logic            fpu_busy_i;
    logic [Width-1:0] rsp_result_o;
    logic [4:0]      rsp_status_o;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic            spurious_o;
    logic            busy_o;

    // Environment side: core dispatch port plus the FPU instance.
    modport master (
        output flush_i, req_i, req_valid_i, fpu_in_ready_i,
        output fpu_result_i, fpu_status_i, fpu_tag_i, fpu_out_valid_i, fpu_busy_i,
        output rsp_ready_i,
        input  req_ready_o, fpu_req_o, fpu_tag_o, fpu_in_valid_o, fpu_flush_o,
        input  fpu_out_ready_o, rsp_result_o, rsp_status_o, rsp_valid_o,
        input  spurious_o, busy_o
    );

    // Reorder-buffer side.
    modport slave (
        input  flush_i, req_i, req_valid_i, fpu_in_ready_i,
        input  fpu_result_i, fpu_status_i, fpu_tag_i, fpu_out_valid_i, fpu_busy_i,
        input  rsp_ready_i,
        output req_ready_o, fpu_req_o, fpu_tag_o, fpu_in_valid_o, fpu_flush_o,
        output fpu_out_ready_o, rsp_result_o, rsp_status_o, rsp_valid_o,
        output spurious_o, busy_o
    );
endinterface

// File: rtl/fpnew_issue_rob.sv
// Tags FP requests on issue and returns out-of-order FPU results to the core
// in issue order through a small reorder buffer.
module fpnew_issue_rob #(
    parameter int unsigned Width   = 64,
    parameter int unsigned NumTags = 4,
    parameter type         ReqType = logic
) (
    input logic             clk_i,
    input logic             rst_ni,
    fpnew_issue_rob_if.slave bus
);
    localparam int unsigned TagW = (NumTags > 1) ? $clog2(NumTags) : 1;
    localparam int unsigned CntW = TagW + 1;

    logic [TagW-1:0]  alloc_ptr;
    logic [TagW-1:0]  retire_ptr;
    logic [CntW-1:0]  count;
    logic [NumTags-1:0] pending;
    logic [NumTags-1:0] done;
    logic [Width-1:0] result_q [NumTags];
    logic [4:0]       status_q [NumTags];
    logic             spurious_q;

    logic full;
    logic issue_fire;
    logic wb_valid;
    logic wb_hit;
    logic retire_fire;

    // Full is taken from the registered count: no same-cycle retire bypass.
    assign full        = (count == CntW'(NumTags));
    assign wb_valid    = bus.fpu_out_valid_i & ~bus.flush_i;
    assign wb_hit      = wb_valid & pending[bus.fpu_tag_i] & ~done[bus.fpu_tag_i];
    assign retire_fire = done[retire_ptr] & bus.rsp_ready_i & ~bus.flush_i;
    assign issue_fire  = bus.fpu_in_valid_o & bus.fpu_in_ready_i;

    assign bus.fpu_in_valid_o  = bus.req_valid_i & ~full & ~bus.flush_i;
    assign bus.req_ready_o     = issue_fire;
    assign bus.fpu_req_o       = bus.req_i;
    assign bus.fpu_tag_o       = alloc_ptr;
    assign bus.fpu_flush_o     = bus.flush_i;
    assign bus.fpu_out_ready_o = 1'b1;

    assign bus.rsp_valid_o  = done[retire_ptr];
    assign bus.rsp_result_o = result_q[retire_ptr];
    assign bus.rsp_status_o = status_q[retire_ptr];
    assign bus.spurious_o   = spurious_q;
    assign bus.busy_o       = (count != '0) | bus.fpu_busy_i;

    // Pointers, occupancy and the drop pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_ptr  <= '0;
            retire_ptr <= '0;
            count      <= '0;
            spurious_q <= 1'b0;
        end else if (bus.flush_i) begin
            alloc_ptr  <= '0;
            retire_ptr <= '0;
            count      <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (issue_fire)  alloc_ptr  <= alloc_ptr + TagW'(1);
            if (retire_fire) retire_ptr <= retire_ptr + TagW'(1);
            count      <= count + CntW'(issue_fire) - CntW'(retire_fire);
            spurious_q <= wb_valid & ~wb_hit;
        end
    end

    // Entry flags; issue, writeback and retire never target the same live slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending <= '0;
            done    <= '0;
        end else if (bus.flush_i) begin
            pending <= '0;
            done    <= '0;
        end else begin
            if (retire_fire) begin
                pending[retire_ptr] <= 1'b0;
                done[retire_ptr]    <= 1'b0;
            end
            if (wb_hit) done[bus.fpu_tag_i] <= 1'b1;
            if (issue_fire) begin
                pending[alloc_ptr] <= 1'b1;
                done[alloc_ptr]    <= 1'b0;
            end
        end
    end

    // Result storage, written only by an accepted writeback.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumTags); i++) begin
                result_q[i] <= '0;
                status_q[i] <= '0;
            end
        end else if (wb_hit) begin
            result_q[bus.fpu_tag_i] <= bus.fpu_result_i;
            status_q[bus.fpu_tag_i] <= bus.fpu_status_i;
        end
    end
endmodule

// File: tb/tb_fpnew_issue_rob.sv
// Directed bench for fpnew_issue_rob: single op, out-of-order return, full,
// response backpressure, flush and duplicate tag.
module tb_fpnew_issue_rob;
    typedef logic [15:0] req_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    fpnew_issue_rob_if #(.Width(64), .TagW(2), .ReqType(req_t)) bus ();

    fpnew_issue_rob #(.Width(64), .NumTags(4), .ReqType(req_t)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_i         = 1'b0;
        bus.req_i           = '0;
        bus.req_valid_i     = 1'b0;
        bus.fpu_in_ready_i  = 1'b1;
        bus.fpu_result_i    = '0;
        bus.fpu_status_i    = '0;
        bus.fpu_tag_i       = '0;
        bus.fpu_out_valid_i = 1'b0;
        bus.fpu_busy_i      = 1'b0;
        bus.rsp_ready_i     = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rst_spurious",  64'(bus.spurious_o),  64'd0);
        check("rst_busy",      64'(bus.busy_o),      64'd0);
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // Issue one op, expecting the given tag, and advance through the fire edge.
    task automatic issue(input req_t req, input logic [1:0] exp_tag);
        bus.req_i       = req;
        bus.req_valid_i = 1'b1;
        #1;
        check("issue_valid", 64'(bus.fpu_in_valid_o), 64'd1);
        check("issue_ready", 64'(bus.req_ready_o),    64'd1);
        check("issue_tag",   64'(bus.fpu_tag_o),      64'(exp_tag));
        check("issue_req",   64'(bus.fpu_req_o),      64'(req));
        step();
        bus.req_valid_i = 1'b0;
    endtask

    // Present one FPU result for a single cycle.
    task automatic ret(input logic [1:0] tag, input logic [63:0] res, input logic [4:0] st);
        bus.fpu_tag_i       = tag;
        bus.fpu_result_i    = res;
        bus.fpu_status_i    = st;
        bus.fpu_out_valid_i = 1'b1;
        step();
        bus.fpu_out_valid_i = 1'b0;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        idle_inputs();
        do_reset();

        // Single op
        check("idle_req_ready", 64'(bus.req_ready_o), 64'd0);
        check("idle_out_ready", 64'(bus.fpu_out_ready_o), 64'd1);
        issue(16'hA5A5, 2'd0);
        check("s1_busy", 64'(bus.busy_o), 64'd1);
        step();
        step();
        bus.fpu_tag_i       = 2'd0;
        bus.fpu_result_i    = 64'h4000000000000000;
        bus.fpu_status_i    = 5'd0;
        bus.fpu_out_valid_i = 1'b1;
        #1;
        check("s1_no_rsp_yet", 64'(bus.rsp_valid_o), 64'd0);
        step();
        bus.fpu_out_valid_i = 1'b0;
        #1;
        check("s1_rsp_valid",  64'(bus.rsp_valid_o),  64'd1);
        check("s1_rsp_result", bus.rsp_result_o,      64'h4000000000000000);
        check("s1_rsp_status", 64'(bus.rsp_status_o), 64'd0);
        bus.rsp_ready_i = 1'b1;
        step();
        bus.rsp_ready_i = 1'b0;
        #1;
        check("s1_rsp_done", 64'(bus.rsp_valid_o), 64'd0);
        check("s1_count0",   64'(bus.busy_o),      64'd0);

        // Out-of-order return
        do_reset();
        issue(16'h0010, 2'd0);
        issue(16'h0011, 2'd1);
        issue(16'h0012, 2'd2);
        ret(2'd2, 64'h2222, 5'h01);
        check("ooo_wait_head", 64'(bus.rsp_valid_o), 64'd0);
        ret(2'd0, 64'h0000_0000_0000_1000, 5'h10);
        check("ooo_r0_valid",  64'(bus.rsp_valid_o),  64'd1);
        check("ooo_r0_result", bus.rsp_result_o,      64'h1000);
        check("ooo_r0_status", 64'(bus.rsp_status_o), 64'h10);
        bus.rsp_ready_i = 1'b1;
        ret(2'd1, 64'h1111, 5'h04);
        check("ooo_r1_valid",  64'(bus.rsp_valid_o),  64'd1);
        check("ooo_r1_result", bus.rsp_result_o,      64'h1111);
        step();
        check("ooo_r2_valid",  64'(bus.rsp_valid_o),  64'd1);
        check("ooo_r2_result", bus.rsp_result_o,      64'h2222);
        check("ooo_r2_status", 64'(bus.rsp_status_o), 64'h01);
        step();
        bus.rsp_ready_i = 1'b0;
        check("ooo_empty", 64'(bus.rsp_valid_o), 64'd0);
        check("ooo_idle",  64'(bus.busy_o),      64'd0);

        // Full buffer and wrap-around
        do_reset();
        for (int i = 0; i < 4; i++) issue(req_t'(16'h0100 + i), 2'(i));
        bus.req_i       = 16'h0BEE;
        bus.req_valid_i = 1'b1;
        #1;
        check("full_in_valid",  64'(bus.fpu_in_valid_o), 64'd0);
        check("full_req_ready", 64'(bus.req_ready_o),    64'd0);
        ret(2'd0, 64'hABCD, 5'h00);
        bus.rsp_ready_i = 1'b1;
        #1;
        check("full_rsp_valid",     64'(bus.rsp_valid_o), 64'd1);
        check("full_no_bypass",     64'(bus.req_ready_o), 64'd0);
        step();
        bus.rsp_ready_i = 1'b0;
        #1;
        check("wrap_req_ready", 64'(bus.req_ready_o), 64'd1);
        check("wrap_tag",       64'(bus.fpu_tag_o),   64'd0);
        step();
        bus.req_valid_i = 1'b0;
        #1;
        check("wrap_full_again", 64'(bus.fpu_in_valid_o), 64'd0);

        // Response backpressure
        do_reset();
        issue(16'h0200, 2'd0);
        issue(16'h0201, 2'd1);
        ret(2'd0, 64'hAAAA_0000, 5'h02);
        ret(2'd1, 64'hBBBB_0000, 5'h03);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid",  64'(bus.rsp_valid_o), 64'd1);
            check("bp_hold_result", bus.rsp_result_o,     64'hAAAA_0000);
            step();
        end
        bus.rsp_ready_i = 1'b1;
        #1;
        check("bp_r0_result", bus.rsp_result_o, 64'hAAAA_0000);
        step();
        check("bp_r1_valid",  64'(bus.rsp_valid_o),  64'd1);
        check("bp_r1_result", bus.rsp_result_o,      64'hBBBB_0000);
        check("bp_r1_status", 64'(bus.rsp_status_o), 64'h03);
        step();
        bus.rsp_ready_i = 1'b0;
        check("bp_drained", 64'(bus.rsp_valid_o), 64'd0);

        // Flush mid-flight
        do_reset();
        issue(16'h0300, 2'd0);
        issue(16'h0301, 2'd1);
        issue(16'h0302, 2'd2);
        bus.flush_i         = 1'b1;
        bus.req_valid_i     = 1'b1;
        bus.fpu_tag_i       = 2'd1;
        bus.fpu_result_i    = 64'h5555;
        bus.fpu_out_valid_i = 1'b1;
        bus.rsp_ready_i     = 1'b1;
        #1;
        check("fl_flush_out",  64'(bus.fpu_flush_o),    64'd1);
        check("fl_no_issue",   64'(bus.fpu_in_valid_o), 64'd0);
        step();
        bus.flush_i         = 1'b0;
        bus.req_valid_i     = 1'b0;
        bus.fpu_out_valid_i = 1'b0;
        #1;
        check("fl_no_rsp",      64'(bus.rsp_valid_o), 64'd0);
        check("fl_count0",      64'(bus.busy_o),      64'd0);
        check("fl_no_spurious", 64'(bus.spurious_o),  64'd0);
        bus.fpu_busy_i = 1'b1;
        ret(2'd2, 64'h6666, 5'h00);
        check("fl_late_spurious", 64'(bus.spurious_o),  64'd1);
        check("fl_late_no_rsp",   64'(bus.rsp_valid_o), 64'd0);
        check("fl_busy_follow",   64'(bus.busy_o),      64'd1);
        step();
        bus.fpu_busy_i  = 1'b0;
        bus.rsp_ready_i = 1'b0;
        #1;
        check("fl_pulse_once", 64'(bus.spurious_o), 64'd0);
        check("fl_busy_low",   64'(bus.busy_o),     64'd0);

        // Duplicate tag
        do_reset();
        issue(16'h0400, 2'd0);
        ret(2'd0, 64'h1234_5678, 5'h08);
        check("dup_first_ok", 64'(bus.spurious_o), 64'd0);
        ret(2'd0, 64'hDEAD_BEEF, 5'h1F);
        check("dup_spurious", 64'(bus.spurious_o),  64'd1);
        check("dup_result",   bus.rsp_result_o,     64'h1234_5678);
        check("dup_status",   64'(bus.rsp_status_o), 64'h08);
        bus.rsp_ready_i = 1'b1;
        step();
        bus.rsp_ready_i = 1'b0;
        check("dup_pulse_end", 64'(bus.spurious_o),  64'd0);
        check("dup_retired",   64'(bus.rsp_valid_o), 64'd0);

        // Reset with an op outstanding emits nothing
        issue(16'h0500, 2'd1);
        ret(2'd1, 64'h7777, 5'h00);
        check("mid_rst_pre", 64'(bus.rsp_valid_o), 64'd1);
        do_reset();
        check("mid_rst_post", 64'(bus.rsp_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
